// File: rtl/uart_tx_feeder.sv
// UART TX feeder: byte FIFO plus a Data_Valid handshake FSM paced by TX_BUSY.
// Optional sticky overflow flag (OVERFLOW/OVF_CLR) enabled by UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  TX_BUSY,
`ifdef UART_TX_FEEDER_OVF_EN
  input  logic                  OVF_CLR,
  output logic                  OVERFLOW,
`endif
  output logic                  FIFO_FULL,
  output logic                  FIFO_EMPTY,
  output logic [ADDR_WIDTH:0]   FIFO_COUNT,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int WCW   = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [WCW-1:0]        r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_dv;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_pop;

  assign w_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full is judged on the current count, so a same-cycle pop never rescues a write.
  assign w_wr    = WR_EN && !w_full;
  assign w_pop   = (r_state == S_WAIT_BUSY) && TX_BUSY;

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The byte stays queued until TX_BUSY confirms acceptance; a missed handshake re-presents it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_p_data   <= '0;
      r_dv       <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty && !TX_BUSY) begin
            r_p_data <= r_mem[r_rd_ptr];
            r_dv     <= 1'b1;
            r_state  <= S_PRESENT;
          end else begin
            r_dv <= 1'b0;
          end
        end
        S_PRESENT: begin
          r_dv       <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (TX_BUSY) begin
            r_state <= S_WAIT_DONE;
          end else if (r_wait_cnt == WCW'(BUSY_WAIT_MAX-1)) begin
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!TX_BUSY) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_dv    <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic r_overflow;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_overflow <= 1'b0;
    end else if (WR_EN && w_full) begin
      r_overflow <= 1'b1;
    end else if (OVF_CLR) begin
      r_overflow <= 1'b0;
    end
  end

  assign OVERFLOW = r_overflow;
`endif

  assign FIFO_FULL  = w_full;
  assign FIFO_EMPTY = w_empty;
  assign FIFO_COUNT = r_count;
  assign P_DATA     = r_p_data;
  assign Data_Valid = r_dv;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a simple TX-core busy model.
module tb_uart_tx_feeder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       TX_BUSY;
  logic       FIFO_FULL;
  logic       FIFO_EMPTY;
  logic [3:0] FIFO_COUNT;
  logic [7:0] P_DATA;
  logic       Data_Valid;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       OVF_CLR;
  logic       OVERFLOW;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_feeder #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (3),
    .BUSY_WAIT_MAX(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .TX_BUSY   (TX_BUSY),
`ifdef UART_TX_FEEDER_OVF_EN
    .OVF_CLR   (OVF_CLR),
    .OVERFLOW  (OVERFLOW),
`endif
    .FIFO_FULL (FIFO_FULL),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_COUNT(FIFO_COUNT),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid)
  );

  always #5 CLK = ~CLK;

  // TX core model: on a sampled Data_Valid, holds busy for frame_len cycles (if responsive).
  bit tx_resp   = 1'b1;
  int frame_len = 3;
  int busy_cnt  = 0;

  always @(posedge CLK) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (Data_Valid === 1'b1 && tx_resp) busy_cnt <= frame_len;
  end
  assign TX_BUSY = (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: log Data_Valid pulses and bytes accepted by the TX model.
  logic [7:0] dv_q[$];
  int         dv_cyc[$];
  logic [7:0] acc_q[$];
  int         cyc = 0;
  logic       prev_busy = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (Data_Valid === 1'b1) begin
      dv_q.push_back(P_DATA);
      dv_cyc.push_back(cyc);
      chk("dv_while_busy", 32'(TX_BUSY), 32'd0);
      chk("dv_while_empty", 32'(FIFO_EMPTY), 32'd0);
      chk("dv_prev_busy", 32'(prev_busy), 32'd0);
    end
    if (TX_BUSY && !prev_busy) acc_q.push_back(P_DATA);
    prev_busy = TX_BUSY;
  end

  task automatic wr(input logic [7:0] d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    @(posedge CLK); #1;
    WR_EN   = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_acc(input int n, input int bound);
    int k = 0;
    while (acc_q.size() < n && k < bound) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("acc_timeout", 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    int quiet = 0;
    while (quiet < 4 && k < bound) begin
      @(posedge CLK); #1;
      k++;
      if (FIFO_EMPTY && !TX_BUSY) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", 32'(quiet >= 4), 32'd1);
  endtask

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       exp_dv;
    logic [7:0] exp_pd;
    logic [3:0] exp_cnt;
    logic       exp_empty;
    logic       exp_busy;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] exp_bytes[$];
  int         n_dv;

  initial begin
    // Single write of 0xA5 with a 3-cycle frame, one row per clock edge.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'hA5, 4'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 8'hA5, 4'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b0};

    RST = 1'b1; WR_EN = 1'b0; WR_DATA = 8'h00;
`ifdef UART_TX_FEEDER_OVF_EN
    OVF_CLR = 1'b0;
`endif
    tx_resp = 1'b1; frame_len = 3;
    cycles(2);
    chk("rst_count", 32'(FIFO_COUNT), 32'd0);
    chk("rst_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("rst_full", 32'(FIFO_FULL), 32'd0);
    chk("rst_dv", 32'(Data_Valid), 32'd0);
    chk("rst_pdata", 32'(P_DATA), 32'd0);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
`endif
    RST = 1'b0;

    for (int i = 0; i < 7; i++) begin
      WR_EN   = tbl[i].wr_en;
      WR_DATA = tbl[i].wr_data;
      @(posedge CLK); #1;
      WR_EN = 1'b0;
      chk($sformatf("v%0d_dv", i), 32'(Data_Valid), 32'(tbl[i].exp_dv));
      chk($sformatf("v%0d_pdata", i), 32'(P_DATA), 32'(tbl[i].exp_pd));
      chk($sformatf("v%0d_count", i), 32'(FIFO_COUNT), 32'(tbl[i].exp_cnt));
      chk($sformatf("v%0d_empty", i), 32'(FIFO_EMPTY), 32'(tbl[i].exp_empty));
      chk($sformatf("v%0d_busy", i), 32'(TX_BUSY), 32'(tbl[i].exp_busy));
    end
    wait_idle(100);

    // Burst of three with 10-cycle frames.
    frame_len = 10;
    acc_q.delete(); dv_q.delete(); dv_cyc.delete();
    wr(8'h11); wr(8'h22); wr(8'h33);
    wait_acc(3, 200);
    wait_idle(200);
    chk("burst_npulse", 32'(dv_q.size()), 32'd3);
    exp_bytes = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++)
      chk($sformatf("burst_b%0d", i), 32'(acc_q.size() > i ? acc_q[i] : 8'hxx), 32'(exp_bytes[i]));

    // Fill to 8 while TX never accepts, then overflow write.
    tx_resp = 1'b0;
    exp_bytes.delete();
    for (int i = 0; i < 8; i++) begin
      wr(8'(8'hC0 + i));
      exp_bytes.push_back(8'(8'hC0 + i));
    end
    chk("fill_count", 32'(FIFO_COUNT), 32'd8);
    chk("fill_full", 32'(FIFO_FULL), 32'd1);
    wr(8'hFF);
    chk("ovf_count", 32'(FIFO_COUNT), 32'd8);
    chk("ovf_full", 32'(FIFO_FULL), 32'd1);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("ovf_set", 32'(OVERFLOW), 32'd1);
    cycles(3);
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);
    OVF_CLR = 1'b1;
    cycles(1);
    OVF_CLR = 1'b0;
    chk("ovf_clr", 32'(OVERFLOW), 32'd0);
`endif
    acc_q.delete();
    frame_len = 2;
    tx_resp = 1'b1;
    wait_acc(8, 300);
    wait_idle(100);
    for (int i = 0; i < 4; i++) begin
      wr(8'(8'hD0 + i));
      exp_bytes.push_back(8'(8'hD0 + i));
    end
    wait_acc(12, 200);
    wait_idle(100);
    chk("drain_n", 32'(acc_q.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("drain_b%0d", i), 32'(acc_q.size() > i ? acc_q[i] : 8'hxx), 32'(exp_bytes[i]));

    // TX never raises busy: same byte re-presented every 6 cycles.
    tx_resp = 1'b0;
    dv_q.delete(); dv_cyc.delete();
    wr(8'h5C);
    for (int k = 0; k < 60 && dv_q.size() < 3; k++) cycles(1);
    chk("retry_npulse", 32'(dv_q.size() >= 3), 32'd1);
    chk("retry_count", 32'(FIFO_COUNT), 32'd1);
    if (dv_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("retry_b%0d", i), 32'(dv_q[i]), 32'h5C);
      chk("retry_gap0", 32'(dv_cyc[1] - dv_cyc[0]), 32'd6);
      chk("retry_gap1", 32'(dv_cyc[2] - dv_cyc[1]), 32'd6);
    end
    frame_len = 3;
    tx_resp = 1'b1;
    wait_idle(100);

    // Simultaneous write and pop at COUNT=4.
    tx_resp = 1'b0;
    acc_q.delete();
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44);
    chk("sim_pre_count", 32'(FIFO_COUNT), 32'd4);
    n_dv = 0;
    while (n_dv < 40) begin
      @(negedge CLK);
      if (Data_Valid) break;
      n_dv++;
    end
    chk("sim_dv_seen", 32'(Data_Valid), 32'd1);
    tx_resp = 1'b1;
    @(posedge CLK); #1;
    WR_EN = 1'b1; WR_DATA = 8'h77;
    @(posedge CLK); #1;
    WR_EN = 1'b0;
    chk("sim_count", 32'(FIFO_COUNT), 32'd4);
    wait_acc(5, 200);
    wait_idle(100);
    exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h77};
    for (int i = 0; i < 5; i++)
      chk($sformatf("sim_b%0d", i), 32'(acc_q.size() > i ? acc_q[i] : 8'hxx), 32'(exp_bytes[i]));

    // Reset while in WAIT_DONE with COUNT=5.
    frame_len = 10;
    for (int i = 0; i < 6; i++) wr(8'(8'h61 + i));
    chk("mid_count", 32'(FIFO_COUNT), 32'd5);
    chk("mid_busy", 32'(TX_BUSY), 32'd1);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    chk("mid_rst_count", 32'(FIFO_COUNT), 32'd0);
    chk("mid_rst_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("mid_rst_dv", 32'(Data_Valid), 32'd0);
    chk("mid_rst_pdata", 32'(P_DATA), 32'd0);
    n_dv = dv_q.size();
    cycles(20);
    chk("mid_no_dv", 32'(dv_q.size()), 32'(n_dv));
    acc_q.delete();
    frame_len = 3;
    wr(8'h99);
    wait_acc(1, 50);
    chk("mid_new_byte", 32'(acc_q.size() > 0 ? acc_q[0] : 8'hxx), 32'h99);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
